// File: rtl/ram_arbiter.sv
// Arbitrates one single-port synchronous RAM between the CPU bus and the VDP fetch port.
// VDP wins contention until the starvation guard forces a CPU grant; reads return via a tagged 2-stage pipe.
module ram_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int VDP_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              vdp_req,
  input  logic [ADDR_W-1:0] vdp_addr,
  output logic              vdp_ack,
  output logic [DATA_W-1:0] vdp_rdata,
  output logic              vdp_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Handshake: a request is held with its address/data until ack; ack is combinational
  // and means the access is issued to the RAM at the end of this same cycle.

  localparam logic [3:0] BURST_MAX = 4'(VDP_BURST_MAX);

  logic [3:0] starve_cnt;
  logic       grant_cpu;
  logic       grant_vdp;
  logic       s1_valid;
  logic       s1_owner;   // 1 = VDP, 0 = CPU

  always_comb begin
    grant_cpu = 1'b0;
    grant_vdp = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (!reset) begin
      if (cpu_req && (!vdp_req || starve_cnt == BURST_MAX)) begin
        grant_cpu = 1'b1;
      end else if (vdp_req) begin
        grant_vdp = 1'b1;
      end
    end
    if (grant_cpu) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else if (grant_vdp) begin
      mem_addr  = vdp_addr;
    end
  end

  assign cpu_ack = grant_cpu;
  assign vdp_ack = grant_vdp;

  // Counts contended cycles lost by the CPU; any gap in cpu_req forgives the debt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!cpu_req || grant_cpu) begin
      starve_cnt <= '0;
    end else if (grant_vdp && starve_cnt != BURST_MAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_owner   <= 1'b0;
      cpu_rvalid <= 1'b0;
      vdp_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      vdp_rdata  <= '0;
    end else begin
      s1_valid   <= (grant_cpu && !cpu_we) || grant_vdp;
      s1_owner   <= grant_vdp;
      cpu_rvalid <= s1_valid && !s1_owner;
      vdp_rvalid <= s1_valid && s1_owner;
      if (s1_valid && !s1_owner) cpu_rdata <= mem_rdata;
      if (s1_valid && s1_owner)  vdp_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: behavioural RAM, shadow memory, per-owner expected queues.
module tb_ram_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ack, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vdp_req = 1'b0;
  logic [ADDR_W-1:0] vdp_addr = '0;
  logic              vdp_ack, vdp_rvalid;
  logic [DATA_W-1:0] vdp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata = '0;

  logic [DATA_W-1:0] ram     [0:65535];
  logic [DATA_W-1:0] ref_mem [0:65535];
  logic [DATA_W-1:0] cpu_q[$], vdp_q[$];
  int                cpu_cyc_q[$], vdp_cyc_q[$];
  int                cyc = 0;
  int                tests = 0, fails = 0;
  logic              last_cpu_ack, last_vdp_ack;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .VDP_BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vdp_req(vdp_req), .vdp_addr(vdp_addr), .vdp_ack(vdp_ack),
    .vdp_rdata(vdp_rdata), .vdp_rvalid(vdp_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Clock / reset-independent infrastructure
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write-then-read single-port RAM
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on each rvalid, check data and the 2-cycle latency
  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
        check("cpu_latency", 32'(cyc), 32'(cpu_cyc_q.pop_front()));
      end
    end
    if (vdp_rvalid) begin
      if (vdp_q.size() == 0) check("vdp_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        check("vdp_rdata", 32'(vdp_rdata), 32'(vdp_q.pop_front()));
        check("vdp_latency", 32'(cyc), 32'(vdp_cyc_q.pop_front()));
      end
    end
  end

  // One cycle: inputs already set after negedge; sample acks, log expectations, advance.
  task automatic tick();
    logic [ADDR_W-1:0] exp_addr;
    #1;
    last_cpu_ack = cpu_ack;
    last_vdp_ack = vdp_ack;
    check("one_grant", 32'(cpu_ack & vdp_ack), 32'd0);
    check("mem_we", 32'(mem_we), 32'(cpu_ack & cpu_we));
    exp_addr = cpu_ack ? cpu_addr : (vdp_ack ? vdp_addr : '0);
    check("mem_addr", 32'(mem_addr), 32'(exp_addr));
    if (cpu_ack && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
    if (cpu_ack && !cpu_we) begin cpu_q.push_back(ref_mem[cpu_addr]); cpu_cyc_q.push_back(cyc + 2); end
    if (vdp_ack) begin vdp_q.push_back(ref_mem[vdp_addr]); vdp_cyc_q.push_back(cyc + 2); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0; vdp_req = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      ram[a] = 8'($urandom_range(0, 255));
      ref_mem[a] = ram[a];
    end
    ram[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;

    // Reset state
    repeat (3) @(negedge clk);
    check("cpu_ack_in_reset", 32'(cpu_ack), 32'd0);
    reset = 1'b0;
    #1;
    check("cpu_rvalid_reset", 32'(cpu_rvalid), 32'd0);
    check("cpu_rdata_reset", 32'(cpu_rdata), 32'd0);
    check("vdp_rdata_reset", 32'(vdp_rdata), 32'd0);
    check("starve_cnt_reset", 32'(dut.starve_cnt), 32'd0);
    @(negedge clk);

    // 1: reset mid-stream kills grants immediately
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; vdp_req = 1'b1; vdp_addr = 16'h0010;
    tick(); tick();
    reset = 1'b1;
    #1;
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_vdp_ack", 32'(vdp_ack), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    cpu_q.delete(); vdp_q.delete(); cpu_cyc_q.delete(); vdp_cyc_q.delete();
    cpu_req = 1'b0; vdp_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk); reset = 1'b0; #1;
    check("rst_starve_cnt", 32'(dut.starve_cnt), 32'd0);
    @(negedge clk);

    // 2: CPU read, latency 2
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    tick();
    check("t2_ack", 32'(last_cpu_ack), 32'd1);
    cpu_req = 1'b0;
    check("t2_rvalid_n1", 32'(cpu_rvalid), 32'd0);
    tick();
    check("t2_rvalid_n2", 32'(cpu_rvalid), 32'd1);
    check("t2_rdata", 32'(cpu_rdata), 32'hA5);
    tick();
    check("t2_rvalid_pulse", 32'(cpu_rvalid), 32'd0);

    // 3: CPU write then VDP read of the same address
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h5A;
    tick();
    check("t3_wr_ack", 32'(last_cpu_ack), 32'd1);
    cpu_req = 1'b0; cpu_we = 1'b0; vdp_req = 1'b1; vdp_addr = 16'h0200;
    tick();
    check("t3_rd_ack", 32'(last_vdp_ack), 32'd1);
    idle(3);
    check("t3_vdp_rdata", 32'(vdp_rdata), 32'h5A);

    // 4: sustained contention gives V,V,V,V,C repeating
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8000; vdp_req = 1'b1; vdp_addr = 16'h0100;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t4_cpu_grant", 32'(last_cpu_ack), 32'((k % 5) == 4));
      check("t4_vdp_grant", 32'(last_vdp_ack), 32'((k % 5) != 4));
      if (last_vdp_ack) vdp_addr = vdp_addr + 16'd1;
    end
    idle(4);

    // 5: interleaved reads every cycle
    cpu_req = 1'b1; cpu_addr = 16'h8000; vdp_req = 1'b1; vdp_addr = 16'h0000;
    for (int k = 0; k < 20 && vdp_req; k++) begin
      if ($urandom_range(0, 3) == 0) cpu_addr = 16'h8000 + 16'($urandom_range(0, 7));
      tick();
      if (last_vdp_ack) begin
        if (vdp_addr == 16'h0007) vdp_req = 1'b0;
        else vdp_addr = vdp_addr + 16'd1;
      end
    end
    check("t5_vdp_done", 32'(vdp_req), 32'd0);
    idle(4);
    check("t5_cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    check("t5_vdp_q_empty", 32'(vdp_q.size()), 32'd0);

    // 6: reset one cycle after a read ack discards the return
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234; vdp_req = 1'b0;
    tick();
    check("t6_ack", 32'(last_cpu_ack), 32'd1);
    cpu_req = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_rvalid_in_reset", 32'(cpu_rvalid | vdp_rvalid), 32'd0);
    cpu_q.delete(); vdp_q.delete(); cpu_cyc_q.delete(); vdp_cyc_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(5);
    check("t6_cpu_q_empty", 32'(cpu_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
